// File: rtl/rvc_asap_5pl_cr_arb.sv
// ---------------------------------------------------------------------------
// rvc_asap_5pl_cr_arb
// Arbiter/sequencer for the single control-register (CR) memory port of the
// 5-stage core. The core pipeline (Q103H memory stage) and a debug requester
// (UART/JTAG bridge) share the port. The core has priority. A debug request
// that core traffic blocks for MAX_WAIT cycles gets a forced slot, and the
// core is stalled for that one cycle. The synchronous CR read data arrives one
// cycle late and is routed back to whichever requester issued the read.
//
// Handshake: DbgReq is a request that the requester holds, with
// DbgWr/DbgAddr/DbgWrData stable, until DbgAck is high in the same cycle. The
// transfer completes in the DbgAck cycle. Read data returns one cycle later
// together with DbgRdValid. The core has no handshake: it re-presents its
// Q103H request in every cycle in which CoreStall is high.
//
// Optional feature (macro RVC_CR_ARB_PERF_CNT_EN): when the macro is defined,
// the block adds saturating 16-bit performance counters (CoreAccCnt,
// DbgAccCnt, StallCnt) and a synchronous clear input, PerfClr.
//
// Ports:
//   Clock, RstN             core clock, async active-low reset
//   CoreWrEn/CoreRdEn/CoreAddr/CoreWrData   core request (Q103H)
//   CoreStall, CoreRdData   core hold request, core load data (Q104H)
//   DbgReq/DbgWr/DbgAddr/DbgWrData          debug request
//   DbgAck, DbgRdValid, DbgRdData           debug accept / read return
//   CtrlCRMemWrEn, SelCRMemWb, CRMemAddr, CRMemWrData   to CR memory
//   CRMemRdDataQ104H        registered read data from CR memory
//   ArbState                current arbiter state (debug observation)
// ---------------------------------------------------------------------------
module rvc_asap_5pl_cr_arb #(
   parameter int MAX_WAIT = 8,
   parameter int WAIT_W   = 8
) (
   input  logic        Clock,
   input  logic        RstN,
   input  logic        CoreWrEn,
   input  logic        CoreRdEn,
   input  logic [31:0] CoreAddr,
   input  logic [31:0] CoreWrData,
   output logic        CoreStall,
   output logic [31:0] CoreRdData,
   input  logic        DbgReq,
   input  logic        DbgWr,
   input  logic [31:0] DbgAddr,
   input  logic [31:0] DbgWrData,
   output logic        DbgAck,
   output logic        DbgRdValid,
   output logic [31:0] DbgRdData,
   output logic        CtrlCRMemWrEn,
   output logic        SelCRMemWb,
   output logic [31:0] CRMemAddr,
   output logic [31:0] CRMemWrData,
   input  logic [31:0] CRMemRdDataQ104H,
   output logic [1:0]  ArbState
`ifdef RVC_CR_ARB_PERF_CNT_EN
  ,input  logic        PerfClr,
   output logic [15:0] CoreAccCnt,
   output logic [15:0] DbgAccCnt,
   output logic [15:0] StallCnt
`endif
);

   typedef enum logic [1:0] {IDLE = 2'd0, DBG_WAIT = 2'd1, DBG_FORCE = 2'd2} state_t;
   typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_CORE_RD = 2'd1, OWN_DBG_RD = 2'd2} owner_t;

   localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

   state_t            state, nxt_state;
   owner_t            owner, nxt_owner;
   logic [WAIT_W-1:0] wait_cnt, nxt_cnt, cnt_inc;
   logic              core_act, core_gnt, dbg_gnt, stall;

   assign core_act = CoreWrEn | CoreRdEn;
   // The counter saturates at MAX_WAIT, so it can never wrap back to a short wait.
   assign cnt_inc  = (wait_cnt >= MAX_WAIT_C) ? wait_cnt : wait_cnt + 1'b1;

   always_comb begin
      core_gnt  = 1'b0;
      dbg_gnt   = 1'b0;
      stall     = 1'b0;
      nxt_state = IDLE;
      nxt_cnt   = '0;
      // Grants are combinational. Gating them with RstN keeps every output
      // at 0 while reset is asserted.
      if (!RstN) begin
         nxt_state = IDLE;
      end else if (state == DBG_FORCE && DbgReq) begin
         dbg_gnt = 1'b1;
         stall   = core_act;
      end else if (core_act) begin
         core_gnt = 1'b1;
         if (DbgReq) begin
            nxt_cnt   = cnt_inc;
            nxt_state = (cnt_inc >= MAX_WAIT_C) ? DBG_FORCE : DBG_WAIT;
         end
      end else if (DbgReq) begin
         dbg_gnt = 1'b1;
      end
   end

   always_comb begin
      CtrlCRMemWrEn = 1'b0;
      SelCRMemWb    = 1'b0;
      CRMemAddr     = '0;
      CRMemWrData   = '0;
      nxt_owner     = OWN_NONE;
      if (core_gnt) begin
         // A write wins when both enables are set. No read is issued in that case.
         CtrlCRMemWrEn = CoreWrEn;
         SelCRMemWb    = CoreRdEn & ~CoreWrEn;
         CRMemAddr     = CoreAddr;
         CRMemWrData   = CoreWrData;
         if (CoreRdEn && !CoreWrEn) nxt_owner = OWN_CORE_RD;
      end else if (dbg_gnt) begin
         CtrlCRMemWrEn = DbgWr;
         SelCRMemWb    = ~DbgWr;
         CRMemAddr     = DbgAddr;
         CRMemWrData   = DbgWrData;
         if (!DbgWr) nxt_owner = OWN_DBG_RD;
      end
   end

   always_ff @(posedge Clock or negedge RstN) begin
      if (!RstN) begin
         state    <= IDLE;
         wait_cnt <= '0;
         owner    <= OWN_NONE;
      end else begin
         state    <= nxt_state;
         wait_cnt <= nxt_cnt;
         owner    <= nxt_owner;
      end
   end

   assign DbgAck     = dbg_gnt;
   assign CoreStall  = stall;
   assign ArbState   = state;
   assign CoreRdData = (owner == OWN_CORE_RD) ? CRMemRdDataQ104H : 32'h0;
   assign DbgRdValid = (owner == OWN_DBG_RD);
   assign DbgRdData  = (owner == OWN_DBG_RD) ? CRMemRdDataQ104H : 32'h0;

   // The core must never load and store in the same Q103H cycle.
   a_core_rd_wr_excl: assert property (@(posedge Clock) disable iff (!RstN)
      !(CoreWrEn && CoreRdEn));

`ifdef RVC_CR_ARB_PERF_CNT_EN
   always_ff @(posedge Clock or negedge RstN) begin
      if (!RstN) begin
         CoreAccCnt <= '0;
         DbgAccCnt  <= '0;
         StallCnt   <= '0;
      end else if (PerfClr) begin
         CoreAccCnt <= '0;
         DbgAccCnt  <= '0;
         StallCnt   <= '0;
      end else begin
         if (core_gnt && CoreAccCnt != 16'hFFFF) CoreAccCnt <= CoreAccCnt + 16'd1;
         if (dbg_gnt  && DbgAccCnt  != 16'hFFFF) DbgAccCnt  <= DbgAccCnt  + 16'd1;
         if (stall    && StallCnt   != 16'hFFFF) StallCnt   <= StallCnt   + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_rvc_asap_5pl_cr_arb.sv
// ---------------------------------------------------------------------------
// Testbench for rvc_asap_5pl_cr_arb. A behavioural CR memory (16 words,
// registered read) sits behind the arbiter. The bench keeps its own model
// array, updated from the intended transactions, and uses it to predict read
// return data. The per-cycle expected return (kind + data) is pushed to
// exp_q when a step is driven and popped in the following cycle.
// ---------------------------------------------------------------------------
module tb_rvc_asap_5pl_cr_arb;

   localparam logic [31:0] A_SEG7 = 32'h00;
   localparam logic [31:0] A_LED  = 32'h04;
   localparam logic [31:0] A_CUR  = 32'h08;
   localparam logic [31:0] A_BTN  = 32'h0C;
   localparam logic [31:0] A_SW   = 32'h10;
   localparam logic [1:0]  K_NONE = 2'd0;
   localparam logic [1:0]  K_CORE = 2'd1;
   localparam logic [1:0]  K_DBG  = 2'd2;
   localparam int          W      = 34;

   logic        Clock = 1'b0;
   logic        RstN;
   logic        CoreWrEn, CoreRdEn, DbgReq, DbgWr;
   logic [31:0] CoreAddr, CoreWrData, DbgAddr, DbgWrData;
   logic        CoreStall, DbgAck, DbgRdValid, CtrlCRMemWrEn, SelCRMemWb;
   logic [31:0] CoreRdData, DbgRdData, CRMemAddr, CRMemWrData;
   logic [31:0] rd_q = 32'h0;
   logic [1:0]  ArbState;
   logic        PerfClr;
`ifdef RVC_CR_ARB_PERF_CNT_EN
   logic [15:0] CoreAccCnt, DbgAccCnt, StallCnt;
`endif

   logic [31:0] cr_mem [16];
   logic [31:0] model  [16];
   logic [W-1:0] exp_q[$];
   int vec_cnt = 0;
   int err_cnt = 0;
   int exp_core_acc = 0, exp_dbg_acc = 0, exp_stall = 0;

   // ---- clock ----
   always #5 Clock = ~Clock;

   // ---- behavioural CR memory ----
   always @(posedge Clock) begin
      if (CtrlCRMemWrEn) cr_mem[CRMemAddr[5:2]] <= CRMemWrData;
      rd_q <= SelCRMemWb ? cr_mem[CRMemAddr[5:2]] : 32'h0;
   end

   rvc_asap_5pl_cr_arb #(.MAX_WAIT(8), .WAIT_W(8)) dut (
      .Clock(Clock), .RstN(RstN),
      .CoreWrEn(CoreWrEn), .CoreRdEn(CoreRdEn), .CoreAddr(CoreAddr), .CoreWrData(CoreWrData),
      .CoreStall(CoreStall), .CoreRdData(CoreRdData),
      .DbgReq(DbgReq), .DbgWr(DbgWr), .DbgAddr(DbgAddr), .DbgWrData(DbgWrData),
      .DbgAck(DbgAck), .DbgRdValid(DbgRdValid), .DbgRdData(DbgRdData),
      .CtrlCRMemWrEn(CtrlCRMemWrEn), .SelCRMemWb(SelCRMemWb),
      .CRMemAddr(CRMemAddr), .CRMemWrData(CRMemWrData),
      .CRMemRdDataQ104H(rd_q), .ArbState(ArbState)
`ifdef RVC_CR_ARB_PERF_CNT_EN
     ,.PerfClr(PerfClr), .CoreAccCnt(CoreAccCnt), .DbgAccCnt(DbgAccCnt), .StallCnt(StallCnt)
`endif
   );

   // ---- comparison ----
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---- driver: one directed cycle with explicit expected ack/stall ----
   task automatic step(input logic cwr, input logic crd, input logic [31:0] caddr,
                       input logic [31:0] cdata, input logic dreq, input logic dwr,
                       input logic [31:0] daddr, input logic [31:0] ddata,
                       input logic exp_ack, input logic exp_stl, input string tag);
      logic         core_g;
      logic [W-1:0] ent;
      logic [31:0]  e_wr, e_sel, e_addr, e_wd;
      CoreWrEn = cwr; CoreRdEn = crd; CoreAddr = caddr; CoreWrData = cdata;
      DbgReq = dreq; DbgWr = dwr; DbgAddr = daddr; DbgWrData = ddata;
      #3;
      core_g = (cwr | crd) && !exp_ack;
      chk({tag, ".ack"},   DbgAck,    exp_ack);
      chk({tag, ".stall"}, CoreStall, exp_stl);
      if (exp_stl) chk({tag, ".state"}, ArbState, 2'd2);
      e_wr = 0; e_sel = 0; e_addr = 0; e_wd = 0;
      if (exp_ack) begin
         e_wr = dwr; e_sel = !dwr; e_addr = daddr; e_wd = ddata;
      end else if (core_g) begin
         e_wr = cwr; e_sel = crd && !cwr; e_addr = caddr; e_wd = cdata;
      end
      chk({tag, ".wren"},   CtrlCRMemWrEn, e_wr);
      chk({tag, ".sel"},    SelCRMemWb,    e_sel);
      chk({tag, ".addr"},   CRMemAddr,     e_addr);
      chk({tag, ".wrdata"}, CRMemWrData,   e_wd);
      // read return for the previous cycle's grant
      vec_cnt++;
      assert (exp_q.size() != 0) else begin
         err_cnt++;
         $error("FAIL %s.queue: observed empty expected entry", tag);
      end
      if (exp_q.size() != 0) begin
         ent = exp_q.pop_front();
         chk({tag, ".core_rd"}, CoreRdData, (ent[33:32] == K_CORE) ? ent[31:0] : 32'h0);
         chk({tag, ".dbg_vld"}, DbgRdValid, ent[33:32] == K_DBG);
         chk({tag, ".dbg_rd"},  DbgRdData,  (ent[33:32] == K_DBG) ? ent[31:0] : 32'h0);
      end
      // expected return for this cycle's grant, then model update
      if (exp_ack && !dwr)           exp_q.push_back({K_DBG, model[daddr[5:2]]});
      else if (core_g && crd && !cwr) exp_q.push_back({K_CORE, model[caddr[5:2]]});
      else                            exp_q.push_back({K_NONE, 32'h0});
      if (exp_ack && dwr)       model[daddr[5:2]] = ddata;
      else if (core_g && cwr)   model[caddr[5:2]] = cdata;
      if (PerfClr) begin
         exp_core_acc = 0; exp_dbg_acc = 0; exp_stall = 0;
      end else begin
         exp_core_acc += int'(core_g);
         exp_dbg_acc  += int'(exp_ack);
         exp_stall    += int'(exp_stl);
      end
      @(posedge Clock); #1;
   endtask

   task automatic idle(input string tag);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
   endtask

   // ---- directed sequence ----
   initial begin
      for (int i = 0; i < 16; i++) begin
         cr_mem[i] = 32'h0; model[i] = 32'h0;
      end
      cr_mem[1] = 32'h0C3; model[1] = 32'h0C3;   // LED
      cr_mem[2] = 32'h03C; model[2] = 32'h03C;   // cursor
      cr_mem[3] = 32'h001; model[3] = 32'h001;   // buttons
      cr_mem[4] = 32'h2A5; model[4] = 32'h2A5;   // switches
      PerfClr = 1'b0;
      RstN = 1'b0;
      CoreWrEn = 1'b0; CoreRdEn = 1'b1; CoreAddr = A_LED; CoreWrData = 32'h0;
      DbgReq = 1'b1; DbgWr = 1'b0; DbgAddr = A_SW; DbgWrData = 32'h0;

      // reset with requests asserted: everything must read 0
      repeat (2) @(posedge Clock);
      #1;
      chk("rst.ack",    DbgAck,        1'b0);
      chk("rst.stall",  CoreStall,     1'b0);
      chk("rst.wren",   CtrlCRMemWrEn, 1'b0);
      chk("rst.sel",    SelCRMemWb,    1'b0);
      chk("rst.addr",   CRMemAddr,     32'h0);
      chk("rst.wrdata", CRMemWrData,   32'h0);
      chk("rst.core_rd", CoreRdData,   32'h0);
      chk("rst.dbg_vld", DbgRdValid,   1'b0);
      chk("rst.dbg_rd",  DbgRdData,    32'h0);
      chk("rst.state",   ArbState,     2'd0);
      DbgReq = 1'b0;
      RstN = 1'b1;
      exp_q.push_back({K_NONE, 32'h0});

      // first cycle after reset: core read of LED
      step(0, 1, A_LED, 0, 0, 0, 0, 0, 0, 0, "first_core_led");
      // core idle, debug read of switches
      step(0, 0, 0, 0, 1, 0, A_SW, 0, 1, 0, "dbg_sw");
      idle("idle0");

      // core stores every cycle, debug write held: forced slot in cycle 9
      for (int i = 1; i <= 8; i++)
         step(1, 0, A_LED, 32'h100 + i, 1, 1, A_SEG7, 32'h77, 0, 0, "starve");
      step(1, 0, A_LED, 32'h109, 1, 1, A_SEG7, 32'h77, 1, 1, "force");
      step(1, 0, A_LED, 32'h109, 0, 0, 0, 0, 0, 0, "after_force");
      step(0, 1, A_LED, 0, 0, 0, 0, 0, 0, 0, "rd_led_back");
      step(0, 0, 0, 0, 1, 0, A_SEG7, 0, 1, 0, "rd_seg7_back");

      // interleaved core/debug reads
      step(0, 1, A_LED, 0, 0, 0, 0, 0, 0, 0, "il_core_led");
      step(0, 0, 0, 0, 1, 0, A_SW, 0, 1, 0, "il_dbg_sw");
      step(0, 1, A_SW, 0, 0, 0, 0, 0, 0, 0, "il_core_sw");
      step(0, 0, 0, 0, 1, 0, A_LED, 0, 1, 0, "il_dbg_led");
      step(0, 1, A_SEG7, 0, 1, 0, A_CUR, 0, 0, 0, "il_both");
      step(0, 0, 0, 0, 1, 0, A_CUR, 0, 1, 0, "il_dbg_after");
      idle("idle1");

      // request dropped after 3 blocked cycles restarts the wait count
      for (int i = 0; i < 3; i++)
         step(1, 0, A_CUR, 32'h200 + i, 1, 0, A_BTN, 0, 0, 0, "drop_wait");
      step(1, 0, A_CUR, 32'h210, 0, 0, 0, 0, 0, 0, "drop_low");
      for (int i = 0; i < 8; i++)
         step(1, 0, A_CUR, 32'h220 + i, 1, 0, A_BTN, 0, 0, 0, "rewait");
      step(1, 0, A_CUR, 32'h228, 1, 0, A_BTN, 0, 1, 1, "reforce");
      step(1, 0, A_CUR, 32'h228, 0, 0, 0, 0, 0, 0, "post_reforce");
      step(0, 1, A_CUR, 0, 0, 0, 0, 0, 0, 0, "rd_cur");
      idle("idle2");

`ifdef RVC_CR_ARB_PERF_CNT_EN
      chk("perf.core",  CoreAccCnt, exp_core_acc[15:0]);
      chk("perf.dbg",   DbgAccCnt,  exp_dbg_acc[15:0]);
      chk("perf.stall", StallCnt,   exp_stall[15:0]);
      PerfClr = 1'b1;
      step(0, 1, A_LED, 0, 0, 0, 0, 0, 0, 0, "perf_clr");
      PerfClr = 1'b0;
      chk("perf_clr.core",  CoreAccCnt, 16'h0);
      chk("perf_clr.dbg",   DbgAccCnt,  16'h0);
      chk("perf_clr.stall", StallCnt,   16'h0);
      idle("idle3");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
